// File: rtl/ttl_74164_load_ctrl_pkg.sv
// Shared types and elaboration helpers for the 74164 load sequencer.
// Holds the FSM state type and the phase/counter sizing helpers.
package ttl_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Number of low cycles of sr_clk within one bit period.
  function automatic int phase_half(input int div);
    return div / 2;
  endfunction

  // Counter width that never collapses to zero bits.
  function automatic int cnt_bits(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic bit params_ok(input int nreq, input int div, input int clr_cyc);
    return (nreq >= 2) && (div >= 2) && ((div % 2) == 0) && (clr_cyc >= 1);
  endfunction

endpackage

// File: rtl/ttl_74164_load_ctrl_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int PTR_W = 1
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [NREQ-1:0]  o_win,
  output logic [PTR_W-1:0] o_win_idx,
  output logic             o_any
);

  int w_idx;

  always_comb begin
    o_win     = '0;
    o_win_idx = '0;
    o_any     = 1'b0;
    w_idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = (int'(i_ptr) + k) % NREQ;
      if (!o_any && i_req[w_idx]) begin
        o_any        = 1'b1;
        o_win[w_idx] = 1'b1;
        o_win_idx    = PTR_W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/ttl_74164_load_ctrl.sv
// Round-robin load sequencer for a cascaded 74164 chain: optional clear,
// then MSB-first serialisation with a generated shift clock.
module ttl_74164_load_ctrl
  import ttl_ctrl_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NREQ      = 2,
  parameter int SHIFT_DIV = 4,
  parameter int CLEAR_EN  = 1,
  parameter int CLEAR_CYC = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  done,
  output logic                  sr_data,
  output logic                  sr_clk,
  output logic                  sr_mr_n
);

  localparam int PTR_W = cnt_bits(NREQ);
  localparam int BIT_W = $clog2(WIDTH + 1);
  localparam int PH_W  = $clog2(SHIFT_DIV);
  localparam int CLR_W = cnt_bits(CLEAR_CYC);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(SHIFT_DIV - 1);
  localparam logic [PH_W-1:0] PH_HALF = PH_W'(phase_half(SHIFT_DIV));

  if (!params_ok(NREQ, SHIFT_DIV, CLEAR_CYC)) begin : g_param_check
    $error("ttl_74164_load_ctrl: illegal NREQ/SHIFT_DIV/CLEAR_CYC");
  end

  state_t             r_state;
  logic [WIDTH-1:0]   r_buf;
  logic [BIT_W-1:0]   r_bits;
  logic [PH_W-1:0]    r_phase;
  logic [CLR_W-1:0]   r_clr;
  logic [PTR_W-1:0]   r_ptr;
  logic [NREQ-1:0]    r_gnt;
  logic               r_busy, r_done, r_sr_data, r_sr_clk, r_mr_n;

  logic [NREQ-1:0]    w_win;
  logic [PTR_W-1:0]   w_win_idx;
  logic               w_any;
  logic [PTR_W-1:0]   w_ptr_next;
  logic [WIDTH-1:0]   w_sel [NREQ];
  logic [WIDTH-1:0]   w_word;

  rr_arbiter #(.NREQ(NREQ), .PTR_W(PTR_W)) u_arb (
    .i_req     (req),
    .i_ptr     (r_ptr),
    .o_win     (w_win),
    .o_win_idx (w_win_idx),
    .o_any     (w_any)
  );

  // AND-OR word mux driven directly by the one-hot winner.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_sel
    assign w_sel[gi] = req_data[gi*WIDTH +: WIDTH] & {WIDTH{w_win[gi]}};
  end

  always_comb begin
    w_word = '0;
    for (int k = 0; k < NREQ; k++) w_word = w_word | w_sel[k];
  end

  assign w_ptr_next = (w_win_idx == PTR_W'(NREQ - 1)) ? '0 : w_win_idx + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_buf     <= '0;
      r_bits    <= '0;
      r_phase   <= '0;
      r_clr     <= '0;
      r_ptr     <= '0;
      r_gnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_sr_data <= 1'b0;
      r_sr_clk  <= 1'b0;
      r_mr_n    <= 1'b0;
    end else begin
      r_gnt  <= '0;
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_mr_n    <= 1'b1;
          r_busy    <= 1'b0;
          r_sr_clk  <= 1'b0;
          r_sr_data <= 1'b0;
          if (w_any) begin
            r_gnt   <= w_win;
            r_buf   <= w_word;
            r_busy  <= 1'b1;
            r_ptr   <= w_ptr_next;
            r_bits  <= BIT_W'(WIDTH);
            r_phase <= '0;
            r_clr   <= CLR_W'(CLEAR_CYC - 1);
            if (CLEAR_EN != 0) begin
              r_state <= ST_CLEAR;
              r_mr_n  <= 1'b0;
            end else begin
              r_state   <= ST_SHIFT;
              r_sr_data <= w_word[WIDTH-1];
            end
          end
        end
        ST_CLEAR: begin
          if (r_clr == '0) begin
            r_state   <= ST_SHIFT;
            r_mr_n    <= 1'b1;
            r_sr_data <= r_buf[WIDTH-1];
            r_sr_clk  <= 1'b0;
          end else begin
            r_clr <= r_clr - CLR_W'(1);
          end
        end
        ST_SHIFT: begin
          // Data only moves at a period boundary, where sr_clk drops too.
          if (r_phase == PH_LAST) begin
            r_buf    <= r_buf << 1;
            r_bits   <= r_bits - BIT_W'(1);
            r_phase  <= '0;
            r_sr_clk <= 1'b0;
            if (r_bits == BIT_W'(1)) begin
              r_state   <= ST_DONE;
              r_done    <= 1'b1;
              r_sr_data <= 1'b0;
            end else begin
              r_sr_data <= r_buf[WIDTH-2];
            end
          end else begin
            r_phase  <= r_phase + PH_W'(1);
            r_sr_clk <= (r_phase >= PH_HALF - PH_W'(1));
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign gnt     = r_gnt;
  assign busy    = r_busy;
  assign done    = r_done;
  assign sr_data = r_sr_data;
  assign sr_clk  = r_sr_clk;
  assign sr_mr_n = r_mr_n;

endmodule

// File: tb/tb_ttl_74164_load_ctrl.sv
// Bench for the 74164 load sequencer: default instance plus a no-clear 4-bit instance,
// each driving a behavioural shift-chain model with a round-robin reference.
module tb_ttl_74164_load_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = '0;
  logic [15:0] req_data = '0;
  logic [1:0]  gnt;
  logic        busy, done, sr_data, sr_clk, sr_mr_n;

  logic [1:0]  req_b = '0;
  logic [7:0]  req_data_b = '0;
  logic [1:0]  gnt_b;
  logic        busy_b, done_b, sr_data_b, sr_clk_b, sr_mr_n_b;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] chain_a = '0;
  logic [3:0] chain_b = '0;
  int rises_a = 0, rises_b = 0;
  logic prev_clk_a = 1'b0, prev_data_a = 1'b0, prev_clk_b = 1'b0, prev_data_b = 1'b0;
  int mptr_a = 0, mptr_b = 0;

  always #5 clk = ~clk;

  ttl_74164_load_ctrl dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt), .busy(busy),
    .done(done), .sr_data(sr_data), .sr_clk(sr_clk), .sr_mr_n(sr_mr_n)
  );

  ttl_74164_load_ctrl #(.WIDTH(4), .NREQ(2), .SHIFT_DIV(2), .CLEAR_EN(0), .CLEAR_CYC(2)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .req_data(req_data_b), .gnt(gnt_b), .busy(busy_b),
    .done(done_b), .sr_data(sr_data_b), .sr_clk(sr_clk_b), .sr_mr_n(sr_mr_n_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Round-robin reference: first requester at or after the pointer, wrapping.
  function automatic int rr_pick(input logic [1:0] r, input int ptr);
    for (int k = 0; k < 2; k++)
      if (r[(ptr + k) % 2]) return (ptr + k) % 2;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (sr_data !== prev_data_a) chk("a_data_changes_clk_low", {31'd0, sr_clk}, 32'd0);
    if (sr_mr_n === 1'b0) chain_a = 8'h01;
    else if (sr_clk === 1'b1 && prev_clk_a === 1'b0) begin
      chain_a = {chain_a[6:0], sr_data};
      rises_a++;
    end
    prev_clk_a  = sr_clk;
    prev_data_a = sr_data;
    if (sr_data_b !== prev_data_b) chk("b_data_changes_clk_low", {31'd0, sr_clk_b}, 32'd0);
    if (sr_mr_n_b === 1'b0) chain_b = 4'h1;
    else if (sr_clk_b === 1'b1 && prev_clk_b === 1'b0) begin
      chain_b = {chain_b[2:0], sr_data_b};
      rises_b++;
    end
    prev_clk_b  = sr_clk_b;
    prev_data_b = sr_data_b;
  endtask

  // One transfer on the default instance, starting from IDLE.
  task automatic xfer_a(input logic [1:0] reqv, input logic [7:0] w0, input logic [7:0] w1,
                        input bit hold, input bit pulse_mid);
    int win, n, low, extra, idle_cyc;
    bit got;
    logic [7:0] exp_w;
    win   = rr_pick(reqv, mptr_a);
    exp_w = (win == 1) ? w1 : w0;
    req = reqv;
    req_data = {w1, w0};
    tick();
    chk("a_gnt", {30'd0, gnt}, 32'd1 << win);
    chk("a_busy_at_gnt", {31'd0, busy}, 32'd1);
    mptr_a   = (win + 1) % 2;
    rises_a  = 0;
    low      = (sr_mr_n === 1'b0) ? 1 : 0;
    req_data = ~req_data;
    if (!hold) req = '0;
    n = 0; got = 0; extra = 0; idle_cyc = 0;
    while (!got && n < 100) begin
      if (pulse_mid && n == 8) req = 2'b10;
      else if (pulse_mid && n == 9) req = 2'b00;
      tick();
      n++;
      if (sr_mr_n === 1'b0) low++;
      if (gnt !== 2'b00) extra++;
      if (busy !== 1'b1) idle_cyc++;
      if (done === 1'b1) got = 1;
    end
    chk("a_done_seen", {31'd0, got}, 32'd1);
    chk("a_latency", n, 32'd34);
    chk("a_mr_low_cycles", low, 32'd2);
    chk("a_rises", rises_a, 32'd8);
    chk("a_chain", {24'd0, chain_a}, {24'd0, exp_w});
    chk("a_no_regrant", extra, 32'd0);
    chk("a_busy_held", idle_cyc, 32'd0);
    tick();
    chk("a_idle_busy", {31'd0, busy}, 32'd0);
    chk("a_idle_gnt", {30'd0, gnt}, 32'd0);
    $display("[TB] xfer A req=%b winner=%0d word=%h chain=%h latency=%0d", reqv, win, exp_w, chain_a, n + 1);
  endtask

  task automatic xfer_b(input logic [1:0] reqv, input logic [3:0] w0, input logic [3:0] w1);
    int win, n, low;
    bit got;
    logic [3:0] exp_w;
    win   = rr_pick(reqv, mptr_b);
    exp_w = (win == 1) ? w1 : w0;
    req_b = reqv;
    req_data_b = {w1, w0};
    tick();
    chk("b_gnt", {30'd0, gnt_b}, 32'd1 << win);
    mptr_b  = (win + 1) % 2;
    rises_b = 0;
    low     = (sr_mr_n_b === 1'b0) ? 1 : 0;
    req_b   = '0;
    req_data_b = ~req_data_b;
    n = 0; got = 0;
    while (!got && n < 100) begin
      tick();
      n++;
      if (sr_mr_n_b === 1'b0) low++;
      if (done_b === 1'b1) got = 1;
    end
    chk("b_done_seen", {31'd0, got}, 32'd1);
    chk("b_latency", n, 32'd8);
    chk("b_mr_stays_high", low, 32'd0);
    chk("b_rises", rises_b, 32'd4);
    chk("b_chain", {28'd0, chain_b}, {28'd0, exp_w});
    tick();
    chk("b_idle_busy", {31'd0, busy_b}, 32'd0);
    $display("[TB] xfer B req=%b winner=%0d word=%h chain=%h latency=%0d", reqv, win, exp_w, chain_b, n + 1);
  endtask

  initial begin
    int n;
    // Reset state.
    rst = 1'b1;
    tick();
    tick();
    chk("rst_gnt", {30'd0, gnt}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sr_data", {31'd0, sr_data}, 32'd0);
    chk("rst_sr_clk", {31'd0, sr_clk}, 32'd0);
    chk("rst_mr_n", {31'd0, sr_mr_n}, 32'd0);
    chk("rst_mr_n_b", {31'd0, sr_mr_n_b}, 32'd0);
    rst = 1'b0;
    tick();
    chk("rel_mr_n", {31'd0, sr_mr_n}, 32'd1);
    chk("rel_mr_n_b", {31'd0, sr_mr_n_b}, 32'd1);
    chk("rel_busy", {31'd0, busy}, 32'd0);

    // Single requester, classic pattern.
    xfer_a(2'b01, 8'hA5, 8'h00, 1'b0, 1'b0);

    // Both requesting continuously: grants alternate.
    xfer_a(2'b11, 8'h3C, 8'hC3, 1'b1, 1'b0);
    xfer_a(2'b11, 8'h3C, 8'hC3, 1'b1, 1'b0);
    xfer_a(2'b11, 8'h3C, 8'hC3, 1'b1, 1'b0);
    req = '0;

    // Short pulse while busy is lost; the same pulse in IDLE is taken.
    xfer_a(2'b01, 8'h5A, 8'h00, 1'b0, 1'b1);
    xfer_a(2'b10, 8'h00, 8'h96, 1'b0, 1'b0);

    // Reset in the middle of shifting.
    req = 2'b01;
    req_data = 16'h00E7;
    tick();
    req = '0;
    rises_a = 0;
    n = 0;
    while (rises_a < 3 && n < 100) begin
      tick();
      n++;
    end
    chk("mid_reached_bit3", rises_a, 32'd3);
    rst = 1'b1;
    tick();
    chk("mid_rst_sr_clk", {31'd0, sr_clk}, 32'd0);
    chk("mid_rst_mr_n", {31'd0, sr_mr_n}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_gnt", {30'd0, gnt}, 32'd0);
    rst = 1'b0;
    mptr_a = 0;
    mptr_b = 0;
    tick();
    chk("mid_rel_mr_n", {31'd0, sr_mr_n}, 32'd1);
    chk("mid_rel_done", {31'd0, done}, 32'd0);
    xfer_a(2'b11, 8'h81, 8'h7E, 1'b0, 1'b0);

    // No-clear, 4-bit, fast-clock configuration.
    xfer_b(2'b01, 4'hF, 4'h0);
    xfer_b(2'b11, 4'h6, 4'h9);
    xfer_b(2'b11, 4'h6, 4'h9);

    // Randomised transfers against the reference.
    for (int i = 0; i < 6; i++) begin
      xfer_a(2'($urandom_range(1, 3)), 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
      req = '0;
    end
    for (int i = 0; i < 4; i++)
      xfer_b(2'($urandom_range(1, 3)), 4'($urandom), 4'($urandom));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
